// File: rtl/decipher.sv
// decipher: iterative AES-128/192/256 inverse cipher, one round per clock,
// fed by an external registered round-key SRAM addressed by round_key_no.
module decipher (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [3:0]   rounds_total,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic [3:0]   round_key_no,
  output logic         en_o
);
  typedef enum logic [2:0] {IDLE, KWAIT, INIT, ROUND, FINAL} state_t;
  localparam logic [7:0] ISBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };
  state_t       r_state;
  logic [127:0] r_s;
  logic [127:0] w_sub, w_ark, w_mix;
  logic [31:0]  w_m [16];
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // returns {0e*a, 0d*a, 0b*a, 09*a}
  function automatic logic [31:0] mults(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x4 ^ a, x8 ^ x2 ^ a, x8 ^ a};
  endfunction
  // InvShiftRows folded into the S-box source byte selection
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign w_sub[8*i +: 8] = ISBOX[r_s[8*((i % 4) + 4*(((i / 4) - (i % 4) + 4) % 4)) +: 8]];
    assign w_m[i] = mults(w_ark[8*i +: 8]);
  end
  assign w_ark = w_sub ^ key;
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign w_mix[32*c +: 8]    = w_m[4*c][31:24] ^ w_m[4*c+1][15:8]  ^ w_m[4*c+2][23:16] ^ w_m[4*c+3][7:0];
    assign w_mix[32*c+8 +: 8]  = w_m[4*c][7:0]   ^ w_m[4*c+1][31:24] ^ w_m[4*c+2][15:8]  ^ w_m[4*c+3][23:16];
    assign w_mix[32*c+16 +: 8] = w_m[4*c][23:16] ^ w_m[4*c+1][7:0]   ^ w_m[4*c+2][31:24] ^ w_m[4*c+3][15:8];
    assign w_mix[32*c+24 +: 8] = w_m[4*c][15:8]  ^ w_m[4*c+1][23:16] ^ w_m[4*c+2][7:0]   ^ w_m[4*c+3][31:24];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state      <= IDLE;
      r_s          <= '0;
      plaintext    <= '0;
      round_key_no <= '0;
      en_o         <= 1'b0;
    end else begin
      en_o         <= 1'b0;
      round_key_no <= (round_key_no == 4'd0) ? 4'd0 : round_key_no - 4'd1;
      case (r_state)
        IDLE: begin
          round_key_no <= en ? rounds_total : 4'd0;
          if (en) begin
            r_s     <= ciphertext;
            r_state <= KWAIT;
          end
        end
        KWAIT: r_state <= INIT;
        INIT: begin
          r_s     <= r_s ^ key;
          r_state <= ROUND;
        end
        ROUND: begin
          r_s <= w_mix;
          if (round_key_no == 4'd0) r_state <= FINAL;
        end
        FINAL: begin
          plaintext <= w_ark;
          en_o      <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_decipher.sv
// tb_decipher: scoreboard bench for decipher with a registered round-key SRAM model
// and a GF-inverse + affine S-box key expansion.
module tb_decipher;
  localparam logic [255:0] K128 = 256'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] K192 = 256'h17161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] K256 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] CT192 = 128'h91710deca070af6ee0df4c86a47ca9dd;
  localparam logic [127:0] CT256 = 128'h8960494b9049fceabf456751cab7a28e;
  localparam logic [127:0] PT    = 128'hffeeddccbbaa99887766554433221100;
  typedef struct {logic [127:0] pt; int t;} exp_t;
  logic         clk = 1'b0;
  logic         reset, en, en_o;
  logic [3:0]   rounds_total, round_key_no, sram_nr;
  logic [127:0] ciphertext, key, plaintext;
  logic [127:0] rk [16][16];
  logic [7:0]   fsb [256];
  exp_t         sb [$];
  int           n_chk = 0, n_pass = 0, cyc = 0, n_done = 0, n0;
  decipher dut (
    .clk(clk), .reset(reset), .en(en), .rounds_total(rounds_total),
    .ciphertext(ciphertext), .key(key), .plaintext(plaintext),
    .round_key_no(round_key_no), .en_o(en_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    key <= rk[sram_nr][round_key_no];
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk)
    if (en_o === 1'b1) begin
      n_done++;
      if (sb.size() == 0) check("spurious_en_o", 128'd1, 128'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("plaintext", plaintext, e.pt);
        check("latency", 128'(cyc), 128'(e.t));
      end
    end
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
  endfunction
  task automatic build_sbox();
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      fsb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask
  task automatic expand(input logic [255:0] k, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[nr][r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask
  task automatic start(input logic [3:0] nr, input logic [127:0] ct);
    exp_t e;
    en = 1'b1;
    rounds_total = nr;
    ciphertext = ct;
    sram_nr = nr;
    e.pt = PT;
    e.t = cyc + int'(nr) + 3;
    sb.push_back(e);
    @(negedge clk);
    en = 1'b0;
  endtask
  task automatic wait_idle();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (sb.size() != 0) begin
      check("timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    en = 1'b0;
    rounds_total = 4'd0;
    ciphertext = '0;
    sram_nr = 4'd10;
    build_sbox();
    expand(K128, 4);
    expand(K192, 6);
    expand(K256, 8);
    repeat (2) @(negedge clk);
    check("rst_plaintext", plaintext, 128'd0);
    check("rst_round_key_no", 128'(round_key_no), 128'd0);
    check("rst_en_o", 128'(en_o), 128'd0);
    reset = 1'b0;
    @(negedge clk);
    start(4'd10, CT128);
    for (int j = 0; j <= 11; j++) begin
      check($sformatf("rkn_%0d", j), 128'(round_key_no), 128'((10 - j > 0) ? 10 - j : 0));
      @(negedge clk);
    end
    wait_idle();
    check("hold", plaintext, PT);
    start(4'd14, CT256);
    wait_idle();
    start(4'd12, CT192);
    wait_idle();
    // en three cycles after accept must be ignored
    n0 = n_done;
    start(4'd10, CT128);
    repeat (2) @(negedge clk);
    en = 1'b1;
    ciphertext = CT256;
    rounds_total = 4'd14;
    @(negedge clk);
    en = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("single_done", 128'(n_done - n0), 128'd1);
    start(4'd10, CT128);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_plaintext", plaintext, 128'd0);
    check("abort_round_key_no", 128'(round_key_no), 128'd0);
    check("abort_en_o", 128'(en_o), 128'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    n0 = n_done;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", 128'(n_done - n0), 128'd0);
    start(4'd10, CT128);
    wait_idle();
    // back-to-back: accept the next block in the en_o cycle
    start(4'd10, CT128);
    for (int i = 0; i < 30 && en_o !== 1'b1; i++) @(negedge clk);
    start(4'd14, CT256);
    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
